noc_nic: RTL
============

NOC_NIC -- requirements
Module: noc_nic

Interface
REQ-001 SHALL have parameters: XCOORD, 0, this node's X coordinate (4 bits used); YCOORD, 0, this node's Y coordinate (4 bits used); CREDITS, 4, router local-input FIFO depth (initial TX credits); RXDEPTH, 4, local receive FIFO depth (power of 2, >=2).
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have TX ports toward router local input: tx_data_o  out  16  flit; tx_enable_o  out  1  flit valid strobe; tx_credit_i  in  1  one-cycle credit return from router.
REQ-004 SHALL have RX ports from router local output: rx_data_i  in  16  flit; rx_enable_i  in  1  flit valid strobe; rx_credit_o  out  1  one-cycle credit return to router.
REQ-005 SHALL have host TX ports: host_req_i  in  1  send request; host_dest_x_i  in  4  destination X; host_dest_y_i  in  4  destination Y; host_payload_i  in  8  payload; host_ack_o  out  1  request accepted this cycle.
REQ-006 SHALL have host RX ports: host_rx_valid_o  out  1  FIFO non-empty; host_rx_data_o  out  16  head flit; host_rx_ready_i  in  1  host pops head.
REQ-007 SHALL have status ports: err_overflow_o  out  1  sticky RX-overflow or credit-overflow; err_misroute_o  out  1  sticky misaddressed flit; tx_count_o  out  16; rx_count_o  out  16.

Function
REQ-008 Flit format SHALL be [15:8] payload, [7:4] destination X, [3:0] destination Y.
REQ-009 TX FSM SHALL have states IDLE, SEND, STALL.
REQ-010 IDLE: host_req_i with credits>0 -> host_ack_o=1 combinationally, flit registered, go SEND; host_req_i with credits==0 -> go STALL, no ack.
REQ-011 SEND: tx_enable_o=1 with registered flit for exactly one cycle; credit decremented that cycle; next request accepted in SEND if credits after decrement >0 (back-to-back, one flit/cycle), else STALL if requested, else IDLE.
REQ-012 STALL: host_ack_o=0; on credits>0 (including same-cycle tx_credit_i) accept request and go SEND; if host_req_i drops, go IDLE.
REQ-013 Credit counter SHALL be width $clog2(CREDITS+1); simultaneous decrement and tx_credit_i -> unchanged; tx_credit_i at CREDITS with no decrement -> saturate at CREDITS and set err_overflow_o.
REQ-014 RX: rx_enable_i SHALL write rx_data_i into FIFO the same edge; host_rx_data_o/host_rx_valid_o driven from FIFO head (zero-latency show-ahead).
REQ-015 Pop (host_rx_valid_o && host_rx_ready_i) SHALL produce rx_credit_o=1 on the following cycle for exactly one cycle per pop.
REQ-016 Write to full FIFO with same-cycle pop SHALL be accepted; write to full FIFO without pop SHALL be dropped and set err_overflow_o.
REQ-017 Received flit with [7:4]!=XCOORD or [3:0]!=YCOORD SHALL still be stored and set err_misroute_o.
REQ-018 Pointers SHALL wrap modulo RXDEPTH; occupancy counter width $clog2(RXDEPTH+1).

Reset
REQ-019 On rst low: FSM IDLE, credits=CREDITS, FIFO empty, tx_data_o=0, tx_enable_o=0, rx_credit_o=0, host_ack_o=0, host_rx_valid_o=0, error flags 0, counters 0.
REQ-020 Reset mid-SEND SHALL deassert tx_enable_o immediately (asynchronous) and discard the in-flight flit.

Configuration
REQ-021 With NOC_NIC_STATS_EN defined, tx_count_o SHALL increment per tx_enable_o pulse and rx_count_o per accepted RX write, both wrapping at 16 bits; without it both SHALL be tied to 0 and no counter registers exist.

Structure
REQ-022 Package noc_pkg SHALL hold flit_t (packed struct payload/dest_x/dest_y), coordinate width constant, and tx_state_t enum.
REQ-023 RX buffer SHALL be sub-module nic_rx_fifo (parameter DEPTH, push/pop/full/empty/count).

Verification
REQ-024 Reset, host sends 4 flits to (2,3) payload 0xA1..0xA4, no credits returned -> 4 tx_enable_o pulses data 0xA123..0xA423, 5th request held in STALL, host_ack_o=0.
REQ-025 From REQ-024 state, pulse tx_credit_i once -> 5th flit sent next cycle, credits return to 0.
REQ-026 Same-cycle send and tx_credit_i at credits=1 -> counter stays 1, continuous back-to-back sending.
REQ-027 XCOORD=1,YCOORD=1, RXDEPTH=4: inject 5 flits 0x0111 with host_rx_ready_i=0 -> 4 stored, err_overflow_o=1; pop 4 -> 4 rx_credit_o pulses each one cycle after pop, data in order.
REQ-028 Inject 0x0022 at node (1,1) -> flit stored, err_misroute_o=1 until reset.
REQ-029 Assert rst during SEND -> tx_enable_o drops without clk edge; after release credits=CREDITS, tx_count_o=0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types for the network interface: flit layout, coordinate width and TX FSM states.
package noc_pkg;

  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = 8;
  localparam int FLIT_W    = PAYLOAD_W + 2 * COORD_W;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [COORD_W-1:0]   dest_x;
    logic [COORD_W-1:0]   dest_y;
  } flit_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_STALL
  } tx_state_t;

  function automatic flit_t make_flit(input logic [COORD_W-1:0]   x,
                                      input logic [COORD_W-1:0]   y,
                                      input logic [PAYLOAD_W-1:0] p);
    flit_t f;
    f.payload = p;
    f.dest_x  = x;
    f.dest_y  = y;
    return f;
  endfunction

endpackage

// File: rtl/nic_rx_fifo.sv
// Show-ahead receive FIFO; the caller gates push so a write to a full FIFO only lands alongside a pop.
module nic_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);

endmodule

// File: rtl/noc_nic.sv
// Network interface: credit-based flit TX toward the router and a show-ahead RX buffer toward the host.
// Optional traffic counters are built only when NOC_NIC_STATS_EN is defined.
//
// state    | meaning
// TX_IDLE  | no request pending; accept when a credit is held
// TX_SEND  | registered flit on tx_data_o with tx_enable_o high, one credit consumed
// TX_STALL | request refused for lack of credit; waiting for a returned credit
module noc_nic
  import noc_pkg::*;
#(
  parameter int XCOORD  = 0,
  parameter int YCOORD  = 0,
  parameter int CREDITS = 4,
  parameter int RXDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] tx_data_o,
  output logic        tx_enable_o,
  input  logic        tx_credit_i,
  input  logic [15:0] rx_data_i,
  input  logic        rx_enable_i,
  output logic        rx_credit_o,
  input  logic        host_req_i,
  input  logic [3:0]  host_dest_x_i,
  input  logic [3:0]  host_dest_y_i,
  input  logic [7:0]  host_payload_i,
  output logic        host_ack_o,
  output logic        host_rx_valid_o,
  output logic [15:0] host_rx_data_o,
  input  logic        host_rx_ready_i,
  output logic        err_overflow_o,
  output logic        err_misroute_o,
  output logic [15:0] tx_count_o,
  output logic [15:0] rx_count_o
);

  localparam int CRW = $clog2(CREDITS + 1);
  localparam logic [CRW:0]         CRED_MAX = (CRW+1)'(CREDITS);
  localparam logic [COORD_W-1:0]   MY_X     = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0]   MY_Y     = COORD_W'(YCOORD);

  tx_state_t      state;
  logic [CRW-1:0] credits;
  logic [CRW:0]   cred_net;
  logic           cred_ovf;
  logic           sending;
  logic           ack_raw;

  logic                         rx_push;
  logic                         rx_pop;
  logic                         rx_full;
  logic                         rx_empty;
  logic [$clog2(RXDEPTH+1)-1:0] rx_level;
  logic                         rx_drop;
  logic                         rx_misaddr;

  assign sending = (state == TX_SEND);

  // One extra bit so a return at full credit is visible as overflow.
  always_comb begin
    cred_net = {1'b0, credits} + (CRW+1)'(tx_credit_i) - (CRW+1)'(sending);
    cred_ovf = (cred_net > CRED_MAX);
    ack_raw  = 1'b0;
    case (state)
      TX_IDLE: ack_raw = host_req_i && (credits != '0);
      default: ack_raw = host_req_i && (cred_net != '0);
    endcase
  end

  assign host_ack_o = rst & ack_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= TX_IDLE;
      credits     <= CRW'(CREDITS);
      tx_data_o   <= '0;
      tx_enable_o <= 1'b0;
    end else begin
      tx_enable_o <= ack_raw;
      if (ack_raw) tx_data_o <= make_flit(host_dest_x_i, host_dest_y_i, host_payload_i);
      credits <= cred_ovf ? CRED_MAX[CRW-1:0] : cred_net[CRW-1:0];
      case (state)
        TX_IDLE:  state <= ack_raw ? TX_SEND : (host_req_i ? TX_STALL : TX_IDLE);
        TX_SEND:  state <= ack_raw ? TX_SEND : (host_req_i ? TX_STALL : TX_IDLE);
        TX_STALL: state <= ack_raw ? TX_SEND : (host_req_i ? TX_STALL : TX_IDLE);
        default:  state <= TX_IDLE;
      endcase
    end
  end

  assign rx_pop     = host_rx_ready_i && !rx_empty;
  assign rx_push    = rx_enable_i && (!rx_full || rx_pop);
  assign rx_drop    = rx_enable_i && rx_full && !rx_pop;
  assign rx_misaddr = rx_enable_i &&
                      ((rx_data_i[7:4] != MY_X) || (rx_data_i[3:0] != MY_Y));

  nic_rx_fifo #(
    .DEPTH (RXDEPTH),
    .WIDTH (FLIT_W)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_data_i),
    .rdata (host_rx_data_o),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_level)
  );

  assign host_rx_valid_o = (rx_level != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_credit_o    <= 1'b0;
      err_overflow_o <= 1'b0;
      err_misroute_o <= 1'b0;
    end else begin
      rx_credit_o <= rx_pop;
      if (cred_ovf || rx_drop) err_overflow_o <= 1'b1;
      if (rx_misaddr)          err_misroute_o <= 1'b1;
    end
  end

`ifdef NOC_NIC_STATS_EN
  logic [15:0] tx_cnt;
  logic [15:0] rx_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_enable_o) tx_cnt <= tx_cnt + 16'd1;
      if (rx_push)     rx_cnt <= rx_cnt + 16'd1;
    end
  end

  assign tx_count_o = tx_cnt;
  assign rx_count_o = rx_cnt;
`else
  assign tx_count_o = '0;
  assign rx_count_o = '0;
`endif

endmodule
